// File: rtl/i2c_req_arbiter.sv
// i2c_req_arbiter: round-robin arbiter that lets two requesters share a single I2C master.
// Latency: ready is registered one cycle after valid is seen in IDLE, and m_start follows one cycle after ready.
// Backpressure: requests get no ready outside IDLE, including the enforced idle GAP after each transaction.
//
// Ports:
//   aclk, aresetn              clock and async active-low reset
//   reqN_valid/data0/data1     requester N pending transaction and its two data words
//   reqN_ready, reqN_done      one-cycle pulses: accepted/latched, and finished
//   m_data0, m_data1, m_start  latched data and start pulse toward the I2C master
//   m_busy                     master busy indication
//   grant                      one-hot current owner (00 = none)
//   timeout_err                one-cycle pulse, coincident with done, on an aborted transaction
module i2c_req_arbiter #(
  parameter int unsigned GAP_CYCLES     = 500000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        req0_valid,
  input  logic [31:0] req0_data0,
  input  logic [31:0] req0_data1,
  output logic        req0_ready,
  output logic        req0_done,
  input  logic        req1_valid,
  input  logic [31:0] req1_data0,
  input  logic [31:0] req1_data1,
  output logic        req1_ready,
  output logic        req1_done,
  output logic [31:0] m_data0,
  output logic [31:0] m_data1,
  output logic        m_start,
  input  logic        m_busy,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_RUN,
    S_GAP
  } state_t;

  localparam logic [31:0] GAP_LOAD  = 32'(GAP_CYCLES);
  localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  logic [1:0]  ready_q, ready_d;
  logic [1:0]  done_q, done_d;
  logic [1:0]  grant_q, grant_d;
  logic        start_q, start_d;
  logic        tmo_err_q, tmo_err_d;
  logic [31:0] data0_q, data0_d;
  logic [31:0] data1_q, data1_d;
  // 1 = req1 was granted last; reset value makes req0 win the first contention.
  logic        last_q, last_d;
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  logic [31:0] gap_cnt_q, gap_cnt_d;

  logic [31:0] tmo_cnt_inc;
  logic        tmo_hit;
  logic        pick1;
  logic        finish;
  logic        finish_tmo;

  always_comb begin
    state_d     = state_q;
    ready_d     = 2'b00;
    done_d      = 2'b00;
    start_d     = 1'b0;
    tmo_err_d   = 1'b0;
    grant_d     = grant_q;
    data0_d     = data0_q;
    data1_d     = data1_q;
    last_d      = last_q;
    tmo_cnt_d   = tmo_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    finish      = 1'b0;
    finish_tmo  = 1'b0;
    tmo_cnt_inc = tmo_cnt_q + 32'd1;
    tmo_hit     = (tmo_cnt_inc >= TMO_LIMIT);
    // req1 wins when it is the only requester, or when both ask and req0 went last.
    pick1       = req1_valid && (!req0_valid || !last_q);

    case (state_q)
      S_IDLE: begin
        if (req0_valid || req1_valid) begin
          grant_d = pick1 ? 2'b10 : 2'b01;
          ready_d = pick1 ? 2'b10 : 2'b01;
          data0_d = pick1 ? req1_data0 : req0_data0;
          data1_d = pick1 ? req1_data1 : req0_data1;
          last_d  = pick1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        start_d   = 1'b1;
        tmo_cnt_d = 32'd0;
        state_d   = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        tmo_cnt_d = tmo_cnt_inc;
        if (tmo_hit) begin
          finish     = 1'b1;
          finish_tmo = 1'b1;
        end else if (m_busy) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        tmo_cnt_d = tmo_cnt_inc;
        // A normal completion wins over a timeout landing in the same cycle.
        if (!m_busy) begin
          finish = 1'b1;
        end else if (tmo_hit) begin
          finish     = 1'b1;
          finish_tmo = 1'b1;
        end
      end
      S_GAP: begin
        if (gap_cnt_q <= 32'd1) begin
          gap_cnt_d = 32'd0;
          state_d   = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (finish) begin
      done_d    = grant_q;
      tmo_err_d = finish_tmo;
      grant_d   = 2'b00;
      gap_cnt_d = GAP_LOAD;
      // With no gap configured the completion edge lands straight in IDLE.
      state_d   = (GAP_LOAD == 32'd0) ? S_IDLE : S_GAP;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= S_IDLE;
      ready_q   <= 2'b00;
      done_q    <= 2'b00;
      grant_q   <= 2'b00;
      start_q   <= 1'b0;
      tmo_err_q <= 1'b0;
      data0_q   <= 32'd0;
      data1_q   <= 32'd0;
      last_q    <= 1'b1;
      tmo_cnt_q <= 32'd0;
      gap_cnt_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      grant_q   <= grant_d;
      start_q   <= start_d;
      tmo_err_q <= tmo_err_d;
      data0_q   <= data0_d;
      data1_q   <= data1_d;
      last_q    <= last_d;
      tmo_cnt_q <= tmo_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  assign req0_ready  = ready_q[0];
  assign req1_ready  = ready_q[1];
  assign req0_done   = done_q[0];
  assign req1_done   = done_q[1];
  assign grant       = grant_q;
  assign m_start     = start_q;
  assign timeout_err = tmo_err_q;
  assign m_data0     = data0_q;
  assign m_data1     = data1_q;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// tb_i2c_req_arbiter: directed bench for i2c_req_arbiter with a grant scoreboard.
// Two instances: dut_a (GAP_CYCLES=10) for most steps, dut_b (GAP_CYCLES=0) for the no-gap case.
// Master behaviour (m_busy) is driven directly by the directed steps.
module tb_i2c_req_arbiter;

  localparam int GAP = 10;
  localparam int TMO = 50;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  logic aresetn;

  logic [1:0]  a_valid, b_valid;
  logic [31:0] a_d0 [2];
  logic [31:0] a_d1 [2];
  logic [31:0] b_d0 [2];
  logic [31:0] b_d1 [2];
  logic        a_busy, b_busy;
  logic        a_r0r, a_r1r, a_r0d, a_r1d, a_start, a_tmo;
  logic        b_r0r, b_r1r, b_r0d, b_r1d, b_start, b_tmo;
  logic [1:0]  a_grant, b_grant;
  logic [31:0] a_md0, a_md1, b_md0, b_md1;

  i2c_req_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut_a (
    .aclk(aclk), .aresetn(aresetn),
    .req0_valid(a_valid[0]), .req0_data0(a_d0[0]), .req0_data1(a_d1[0]),
    .req0_ready(a_r0r), .req0_done(a_r0d),
    .req1_valid(a_valid[1]), .req1_data0(a_d0[1]), .req1_data1(a_d1[1]),
    .req1_ready(a_r1r), .req1_done(a_r1d),
    .m_data0(a_md0), .m_data1(a_md1), .m_start(a_start), .m_busy(a_busy),
    .grant(a_grant), .timeout_err(a_tmo)
  );

  i2c_req_arbiter #(.GAP_CYCLES(0), .TIMEOUT_CYCLES(TMO)) dut_b (
    .aclk(aclk), .aresetn(aresetn),
    .req0_valid(b_valid[0]), .req0_data0(b_d0[0]), .req0_data1(b_d1[0]),
    .req0_ready(b_r0r), .req0_done(b_r0d),
    .req1_valid(b_valid[1]), .req1_data0(b_d0[1]), .req1_data1(b_d1[1]),
    .req1_ready(b_r1r), .req1_done(b_r1d),
    .m_data0(b_md0), .m_data1(b_md1), .m_start(b_start), .m_busy(b_busy),
    .grant(b_grant), .timeout_err(b_tmo)
  );

  // View of whichever instance the current step targets.
  logic dsel;
  wire [1:0]  v_ready = dsel ? {b_r1r, b_r0r} : {a_r1r, a_r0r};
  wire [1:0]  v_done  = dsel ? {b_r1d, b_r0d} : {a_r1d, a_r0d};
  wire [1:0]  v_grant = dsel ? b_grant : a_grant;
  wire        v_start = dsel ? b_start : a_start;
  wire        v_tmo   = dsel ? b_tmo : a_tmo;
  wire [31:0] v_md0   = dsel ? b_md0 : a_md0;
  wire [31:0] v_md1   = dsel ? b_md1 : a_md1;

  typedef struct packed {
    logic        id;
    logic [31:0] d0;
    logic [31:0] d1;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic tick(input int n);
    repeat (n) @(negedge aclk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic fail_to(input string tag);
    n_checks++;
    n_errors++;
    $display("FAIL %s: observed no event, expected one within the cycle bound", tag);
  endtask

  task automatic drive_valid(input logic id, input logic v);
    if (dsel) b_valid[id] = v;
    else      a_valid[id] = v;
  endtask

  task automatic set_busy(input logic v);
    if (dsel) b_busy = v;
    else      a_busy = v;
  endtask

  task automatic request(input logic id, input logic [31:0] d0, input logic [31:0] d1);
    exp_t e;
    if (dsel) begin b_d0[id] = d0; b_d1[id] = d1; end
    else      begin a_d0[id] = d0; a_d1[id] = d1; end
    drive_valid(id, 1'b1);
    e.id = id; e.d0 = d0; e.d1 = d1;
    exp_q.push_back(e);
  endtask

  // Waits for a ready pulse, checks it against the scoreboard head, then checks m_start follows.
  task automatic accept(input string tag, input int t_ref, input int exp_delta,
                        output int t_rdy, output int t_start);
    exp_t e;
    bit   got;
    got = 1'b0; t_rdy = 0; t_start = 0;
    for (int i = 0; i < 40; i++) begin
      if (|v_ready) begin got = 1'b1; break; end
      tick(1);
    end
    if (!got) begin fail_to({tag, "_ready"}); return; end
    if (exp_q.size() == 0) begin fail_to({tag, "_scoreboard"}); return; end
    e = exp_q.pop_front();
    t_rdy = cyc;
    chk({tag, "_ready"}, 64'(v_ready), e.id ? 64'd2 : 64'd1);
    chk({tag, "_grant"}, 64'(v_grant), e.id ? 64'd2 : 64'd1);
    chk({tag, "_mdata"}, {v_md0, v_md1}, {e.d0, e.d1});
    if (exp_delta >= 0) chk({tag, "_delay"}, 64'(t_rdy - t_ref), 64'(exp_delta));
    drive_valid(e.id, 1'b0);
    tick(1);
    chk({tag, "_start"}, {61'd0, v_ready, v_start}, 64'd1);
    t_start = cyc;
    tick(1);
    chk({tag, "_start_pulse"}, 64'(v_start), 64'd0);
  endtask

  task automatic await_done(input string tag, input logic id, input logic exp_tmo,
                            input int t_ref, input int exp_delta, output int t_done);
    bit got;
    got = 1'b0; t_done = 0;
    for (int i = 0; i < 200; i++) begin
      if (|v_done) begin got = 1'b1; break; end
      tick(1);
    end
    if (!got) begin fail_to({tag, "_done"}); return; end
    t_done = cyc;
    chk({tag, "_done"}, 64'(v_done), id ? 64'd2 : 64'd1);
    chk({tag, "_tmo"}, 64'(v_tmo), 64'(exp_tmo));
    chk({tag, "_grant_clr"}, 64'(v_grant), 64'd0);
    chk({tag, "_done_delay"}, 64'(t_done - t_ref), 64'(exp_delta));
    tick(1);
    chk({tag, "_done_pulse"}, {61'd0, v_done, v_tmo}, 64'd0);
  endtask

  task automatic run_busy(input int len, output int t_fall);
    tick(2);
    set_busy(1'b1);
    tick(len);
    set_busy(1'b0);
    t_fall = cyc;
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_grant"}, 64'(v_grant), 64'd0);
    chk({tag, "_pulses"}, {58'd0, v_ready, v_done, v_start, v_tmo}, 64'd0);
    chk({tag, "_mdata"}, {v_md0, v_md1}, 64'd0);
  endtask

  initial begin
    int   tr, ts, tf, td;
    bit   seen;
    exp_t dummy;
    dsel = 1'b0;
    aresetn = 1'b0;
    a_valid = 2'b00; b_valid = 2'b00;
    a_busy = 1'b0; b_busy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a_d0[i] = '0; a_d1[i] = '0; b_d0[i] = '0; b_d1[i] = '0;
    end

    tick(2);
    rst_chk("reset");
    aresetn = 1'b1;
    tick(1);

    // Single request, normal completion.
    request(1'b0, 32'h0000_00A0, 32'h0000_0055);
    accept("t1", 0, -1, tr, ts);
    run_busy(20, tf);
    await_done("t1", 1'b0, 1'b0, tf, 1, td);
    chk("t1_mdata_hold", {v_md0, v_md1}, {32'h0000_00A0, 32'h0000_0055});

    // Re-request during the gap: accepted one cycle after the 10-cycle gap; then m_busy never rises.
    request(1'b0, 32'h1234_5678, 32'hCAFE_F00D);
    accept("t2", td, GAP + 1, tr, ts);
    await_done("t2", 1'b0, 1'b1, ts, TMO, td);

    // Contention after req0 went last: req1 wins.
    request(1'b1, 32'h0000_00B1, 32'h1111_2222);
    request(1'b0, 32'h0000_00A2, 32'h3333_4444);
    accept("t3", td, GAP + 1, tr, ts);
    run_busy(6, tf);
    await_done("t3", 1'b1, 1'b0, tf, 1, td);
    // req1 comes straight back but req0 has been waiting.
    request(1'b1, 32'h0000_00B3, 32'h5555_6666);
    accept("t4", td, GAP + 1, tr, ts);
    // Master stuck busy.
    set_busy(1'b1);
    await_done("t4", 1'b0, 1'b1, ts, TMO, td);
    set_busy(1'b0);
    accept("t5", td, GAP + 1, tr, ts);
    run_busy(4, tf);
    await_done("t5", 1'b1, 1'b0, tf, 1, td);

    // req0 granted, then reset lands in RUN.
    request(1'b0, 32'h0000_00A6, 32'h7777_8888);
    accept("t6", td, GAP + 1, tr, ts);
    tick(2);
    set_busy(1'b1);
    tick(5);
    aresetn = 1'b0;
    #1;
    rst_chk("midrst");
    tick(1);
    chk("midrst_nodone1", 64'(v_done), 64'd0);
    tick(1);
    chk("midrst_nodone2", 64'(v_done), 64'd0);
    set_busy(1'b0);
    request(1'b0, 32'h0000_00A7, 32'h9999_AAAA);
    request(1'b1, 32'h0000_00B7, 32'hBBBB_CCCC);
    aresetn = 1'b1;
    accept("t7", 0, -1, tr, ts);
    // req1 withdraws before being served.
    drive_valid(1'b1, 1'b0);
    dummy = exp_q.pop_back();
    run_busy(7, tf);
    await_done("t7", 1'b0, 1'b0, tf, 1, td);
    // A valid pulse that ends inside the gap must be ignored.
    drive_valid(1'b1, 1'b1);
    tick(3);
    drive_valid(1'b1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      seen = seen | (|v_ready);
    end
    chk("t7_drop_ignored", 64'(seen), 64'd0);

    // No-gap instance: a request pending at completion is taken in the first IDLE cycle.
    dsel = 1'b1;
    request(1'b0, 32'h0000_00D0, 32'h0000_00D1);
    accept("b1", 0, -1, tr, ts);
    tick(2);
    set_busy(1'b1);
    request(1'b1, 32'h0000_00E0, 32'h0000_00E1);
    tick(3);
    set_busy(1'b0);
    tf = cyc;
    await_done("b1", 1'b0, 1'b0, tf, 1, td);
    accept("b2", td, 1, tr, ts);
    run_busy(2, tf);
    await_done("b2", 1'b1, 1'b0, tf, 1, td);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
